// File: rtl/phase_shift_monitor.sv
// Multi-channel phase checker: measures each channel's rising-edge delay from the
// reference clock in clk ticks and flags deviations from the expected delay.
module phase_shift_monitor #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned CNT_WIDTH      = 12,
  parameter logic [NUM_CH*CNT_WIDTH-1:0] EXPECTED = '0,
  parameter int unsigned TOL            = 2,
  parameter int unsigned SETTLE_PERIODS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ref_in,
  input  logic [NUM_CH-1:0]             ch_in,
  input  logic                          LOCKED,
  output logic [NUM_CH*CNT_WIDTH-1:0]   measured,
  output logic [CNT_WIDTH-1:0]          period,
  output logic [NUM_CH-1:0]             valid,
  output logic [NUM_CH-1:0]             fail,
  output logic                          active
);

  localparam int unsigned SET_W = (SETTLE_PERIODS > 1) ? $clog2(SETTLE_PERIODS) : 1;
  localparam logic [SET_W-1:0]     SETTLE_LAST = SET_W'(SETTLE_PERIODS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [CNT_WIDTH-1:0] TOL_C       = CNT_WIDTH'(TOL);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK} state_t;

  state_t state, state_nxt;
  logic [SET_W-1:0] settle_cnt, settle_nxt;

  logic [1:0]        ref_sync;
  logic              ref_prev;
  logic [NUM_CH-1:0] ch_s1, ch_s2, ch_prev;
  logic [1:0]        lock_sync;
  logic              ref_rise, locked_s, win_start;
  logic [NUM_CH-1:0] ch_rise;

  logic [CNT_WIDTH-1:0] per_cnt;
  logic                 per_seen;

  logic [CNT_WIDTH-1:0]        cnt_q   [NUM_CH];
  logic [CNT_WIDTH-1:0]        cnt_d   [NUM_CH];
  logic [CNT_WIDTH-1:0]        cnt_inc [NUM_CH];
  logic [NUM_CH-1:0]           armed_q, armed_d, valid_d, fail_d, over_tol;
  logic [NUM_CH*CNT_WIDTH-1:0] meas_d;

  // Two-flop synchronizers plus edge-detect stage; equal latency on every input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_sync  <= '0;
      ref_prev  <= 1'b0;
      ch_s1     <= '0;
      ch_s2     <= '0;
      ch_prev   <= '0;
      lock_sync <= '0;
    end else begin
      ref_sync  <= {ref_sync[0], ref_in};
      ref_prev  <= ref_sync[1];
      ch_s1     <= ch_in;
      ch_s2     <= ch_s1;
      ch_prev   <= ch_s2;
      lock_sync <= {lock_sync[0], LOCKED};
    end
  end

  assign ref_rise = ref_sync[1] & ~ref_prev;
  assign ch_rise  = ch_s2 & ~ch_prev;
  assign locked_s = lock_sync[1];

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  // FSM next state; the last settle rise opens the first measurement window
  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    case (state)
      ST_IDLE: begin
        if (locked_s) begin
          state_nxt  = ST_SETTLE;
          settle_nxt = '0;
        end
      end
      ST_SETTLE: begin
        if (!locked_s) begin
          state_nxt = ST_IDLE;
        end else if (ref_rise) begin
          if (settle_cnt == SETTLE_LAST) state_nxt = ST_CHECK;
          else settle_nxt = settle_cnt + SET_W'(1);
        end
      end
      ST_CHECK: begin
        if (!locked_s) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign win_start = ref_rise && (state_nxt == ST_CHECK);

  // Reference period; the first rise after lock only restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt  <= '0;
      per_seen <= 1'b0;
      period   <= '0;
    end else begin
      if (ref_rise) per_cnt <= '0;
      else if (per_cnt != CNT_MAX) per_cnt <= per_cnt + CNT_WIDTH'(1);

      if (state == ST_IDLE) begin
        per_seen <= 1'b0;
      end else if (ref_rise) begin
        per_seen <= 1'b1;
        if (per_seen) period <= (per_cnt == CNT_MAX) ? CNT_MAX : per_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Wrap-aware error: min(d, period - d), falling back to d when period is unknown
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_WIDTH-1:0] meas_g, exp_g, d, alt;
    logic [CNT_WIDTH:0]   diff, wrap;
    logic                 use_wrap;

    assign meas_g   = measured[g*CNT_WIDTH +: CNT_WIDTH];
    assign exp_g    = EXPECTED[g*CNT_WIDTH +: CNT_WIDTH];
    assign diff     = {1'b0, meas_g} - {1'b0, exp_g};
    assign d        = diff[CNT_WIDTH] ? CNT_WIDTH'(-diff) : diff[CNT_WIDTH-1:0];
    assign wrap     = {1'b0, period} - {1'b0, d};
    assign alt      = wrap[CNT_WIDTH-1:0];
    assign use_wrap = (period != '0) && !wrap[CNT_WIDTH] && (alt < d);
    assign over_tol[g] = (use_wrap ? alt : d) > TOL_C;
    assign cnt_inc[g]  = (cnt_q[g] == CNT_MAX) ? CNT_MAX : cnt_q[g] + CNT_WIDTH'(1);
  end

  // Per-channel window tracking and sticky compare
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    valid_d = '0;
    fail_d  = fail;
    meas_d  = measured;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (valid[i] && over_tol[i]) fail_d[i] = 1'b1;

      if (state_nxt != ST_CHECK) begin
        armed_d[i] = 1'b0;
      end else if (win_start) begin
        if (armed_q[i]) begin
          fail_d[i]                          = 1'b1;
          meas_d[i*CNT_WIDTH +: CNT_WIDTH]   = CNT_MAX;
          valid_d[i]                         = 1'b1;
        end
        cnt_d[i] = '0;
        if (ch_rise[i]) begin
          meas_d[i*CNT_WIDTH +: CNT_WIDTH] = '0;
          valid_d[i]                       = 1'b1;
          armed_d[i]                       = 1'b0;
        end else begin
          armed_d[i] = 1'b1;
        end
      end else if (armed_q[i]) begin
        cnt_d[i] = cnt_inc[i];
        if (ch_rise[i]) begin
          meas_d[i*CNT_WIDTH +: CNT_WIDTH] = cnt_inc[i];
          valid_d[i]                       = 1'b1;
          armed_d[i]                       = 1'b0;
        end else if (cnt_inc[i] == CNT_MAX) begin
          fail_d[i]                        = 1'b1;
          meas_d[i*CNT_WIDTH +: CNT_WIDTH] = CNT_MAX;
          valid_d[i]                       = 1'b1;
          armed_d[i]                       = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= '0;
      armed_q  <= '0;
      measured <= '0;
      valid    <= '0;
      fail     <= '0;
      active   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      measured <= meas_d;
      valid    <= valid_d;
      fail     <= fail_d;
      active   <= (state_nxt == ST_CHECK);
    end
  end

endmodule

// File: tb/tb_phase_shift_monitor.sv
// Directed bench: 40-tick reference, four shifted channels, lock/settle, wrap, timeout and reset cases.
module tb_phase_shift_monitor;

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 12;
  localparam logic [NCH*CW-1:0] EXP_MAIN = {12'd30, 12'd20, 12'd10, 12'd0};
  localparam logic [NCH*CW-1:0] EXP_WRAP = {12'd30, 12'd20, 12'd10, 12'd39};

  logic clk, rst, ref_in, LOCKED;
  logic [NCH-1:0] ch_in;

  logic [NCH*CW-1:0] m_meas, w1_meas, w0_meas;
  logic [CW-1:0]     m_per, w1_per, w0_per;
  logic [NCH-1:0]    m_vld, w1_vld, w0_vld, m_fail, w1_fail, w0_fail;
  logic              m_act, w1_act, w0_act;

  int phase, rises, checks, errors, n, r0;
  int shift [NCH];
  int vcnt  [NCH];
  logic [NCH-1:0] hold, vacc, facc;

  phase_shift_monitor #(.NUM_CH(NCH), .CNT_WIDTH(CW), .EXPECTED(EXP_MAIN), .TOL(1), .SETTLE_PERIODS(4)) u_main (
    .clk(clk), .rst(rst), .ref_in(ref_in), .ch_in(ch_in), .LOCKED(LOCKED),
    .measured(m_meas), .period(m_per), .valid(m_vld), .fail(m_fail), .active(m_act));

  phase_shift_monitor #(.NUM_CH(NCH), .CNT_WIDTH(CW), .EXPECTED(EXP_WRAP), .TOL(1), .SETTLE_PERIODS(4)) u_wrap1 (
    .clk(clk), .rst(rst), .ref_in(ref_in), .ch_in(ch_in), .LOCKED(LOCKED),
    .measured(w1_meas), .period(w1_per), .valid(w1_vld), .fail(w1_fail), .active(w1_act));

  phase_shift_monitor #(.NUM_CH(NCH), .CNT_WIDTH(CW), .EXPECTED(EXP_WRAP), .TOL(0), .SETTLE_PERIODS(4)) u_wrap0 (
    .clk(clk), .rst(rst), .ref_in(ref_in), .ch_in(ch_in), .LOCKED(LOCKED),
    .measured(w0_meas), .period(w0_per), .valid(w0_vld), .fail(w0_fail), .active(w0_act));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clk tick per phase step: 40-tick reference, channels delayed by shift[i]
  initial begin
    phase  = 0;
    rises  = 0;
    ref_in = 1'b0;
    ch_in  = '0;
    forever begin
      @(negedge clk);
      phase = (phase == 39) ? 0 : phase + 1;
      if (phase == 0) rises++;
      ref_in = (phase < 20);
      for (int i = 0; i < int'(NCH); i++)
        ch_in[i] = !hold[i] && (((phase + 40 - shift[i]) % 40) < 20);
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_phase(input int p);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (phase != p && k < 100);
    if (phase != p) begin
      checks++;
      errors++;
      $error("FAIL wait_phase: observed %0d expected %0d", phase, p);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    LOCKED = 1'b0;
    hold   = '0;
    shift[0] = 0; shift[1] = 10; shift[2] = 20; shift[3] = 30;

    repeat (5) tick();
    check("rst_measured", 64'(m_meas), 64'd0);
    check("rst_period",   64'(m_per),  64'd0);
    check("rst_valid",    64'(m_vld),  64'd0);
    check("rst_fail",     64'(m_fail), 64'd0);
    check("rst_active",   64'(m_act),  64'd0);
    rst = 1'b0;

    // Unlocked: nothing measured
    vacc = '0;
    repeat (120) begin tick(); vacc |= m_vld; end
    check("unlocked_valid",  64'(vacc),  64'd0);
    check("unlocked_period", 64'(m_per), 64'd0);
    check("unlocked_active", 64'(m_act), 64'd0);

    // Lock and settle over four reference rises
    wait_phase(10);
    LOCKED = 1'b1;
    r0 = rises;
    n = 0;
    while ((rises - r0) < 3 && n < 200) begin tick(); n++; end
    wait_phase(35);
    check("settle_active_low", 64'(m_act), 64'd0);
    wait_phase(5);
    check("settle_rise_count", 64'(rises - r0), 64'd4);
    check("check_active",      64'(m_act),      64'd1);

    // Nominal run of 20 periods
    for (int i = 0; i < int'(NCH); i++) vcnt[i] = 0;
    facc = '0;
    repeat (800) begin
      tick();
      for (int i = 0; i < int'(NCH); i++) vcnt[i] += int'(m_vld[i]);
      facc |= m_fail;
    end
    check("nom_fail",     64'(facc),   64'd0);
    check("nom_measured", 64'(m_meas), 64'(EXP_MAIN));
    check("nom_period",   64'(m_per),  64'd40);
    for (int i = 0; i < int'(NCH); i++) check("nom_valid_count", 64'(vcnt[i]), 64'd20);
    check("wrap_tol1_fail", 64'(w1_fail),        64'd0);
    check("wrap_meas0",     64'(w1_meas[CW-1:0]), 64'd0);
    check("wrap_tol0_fail", 64'(w0_fail),        64'd1);

    // ch2 moved to 25 ticks; fail is sticky after correction
    wait_phase(1);
    shift[2] = 25;
    n = 0;
    while (!m_fail[2] && n < 45) begin tick(); n++; end
    check("ch2_fail_set", 64'(m_fail), 64'h4);
    repeat (80) tick();
    check("ch2_meas_25", 64'(m_meas[2*CW +: CW]), 64'd25);
    check("ch2_fail_hold", 64'(m_fail), 64'h4);
    wait_phase(1);
    shift[2] = 20;
    repeat (80) tick();
    check("ch2_meas_20",  64'(m_meas[2*CW +: CW]), 64'd20);
    check("ch2_fail_sticky", 64'(m_fail), 64'h4);
    check("wrap_tol1_ch0_ok", 64'(w1_fail[0]), 64'd0);

    // ch1 held low: timeout at the next reference rise
    wait_phase(5);
    hold[1] = 1'b1;
    wait_phase(5);
    check("to_meas1", 64'(m_meas[CW +: CW]),   64'hFFF);
    check("to_fail",  64'(m_fail),             64'h6);
    check("to_meas0", 64'(m_meas[0 +: CW]),    64'd0);
    check("to_meas2", 64'(m_meas[2*CW +: CW]), 64'd20);
    check("to_meas3", 64'(m_meas[3*CW +: CW]), 64'd30);
    hold[1] = 1'b0;
    wait_phase(15);
    check("ch1_recover", 64'(m_meas[CW +: CW]), 64'd10);

    // Drop lock mid-window, then relock
    wait_phase(25);
    LOCKED = 1'b0;
    repeat (5) tick();
    check("unlock_active", 64'(m_act), 64'd0);
    vacc = '0;
    repeat (120) begin tick(); vacc |= m_vld; end
    check("unlock_valid",  64'(vacc),             64'd0);
    check("unlock_fail",   64'(m_fail),           64'h6);
    check("unlock_meas1",  64'(m_meas[CW +: CW]), 64'd10);
    check("unlock_period", 64'(m_per),            64'd40);
    LOCKED = 1'b1;
    r0 = rises;
    vacc = '0;
    n = 0;
    while ((rises - r0) < 4 && n < 300) begin tick(); vacc |= m_vld; n++; end
    check("relock_no_valid", 64'(vacc), 64'd0);
    vacc = '0;
    repeat (6) begin tick(); vacc |= m_vld; end
    check("relock_first_valid", 64'(vacc),   64'h1);
    check("relock_active",      64'(m_act),  64'd1);
    check("relock_fail",        64'(m_fail), 64'h6);

    // Asynchronous reset mid-CHECK
    wait_phase(12);
    #1;
    rst = 1'b1;
    #1;
    check("arst_measured", 64'(m_meas), 64'd0);
    check("arst_period",   64'(m_per),  64'd0);
    check("arst_valid",    64'(m_vld),  64'd0);
    check("arst_fail",     64'(m_fail), 64'd0);
    check("arst_active",   64'(m_act),  64'd0);
    repeat (3) tick();
    rst = 1'b0;
    r0 = rises;
    n = 0;
    while (!m_act && n < 400) begin tick(); n++; end
    check("post_rst_settle_rises", 64'(rises - r0), 64'd4);
    repeat (80) tick();
    check("post_rst_fail",     64'(m_fail), 64'd0);
    check("post_rst_measured", 64'(m_meas), 64'(EXP_MAIN));
    check("post_rst_period",   64'(m_per),  64'd40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
